// File: rtl/conv_ctrl.sv
`default_nettype none
// conv_ctrl: walks every valid output pixel of the convolution, issuing X/W read addresses and
// MAC strobes, then hands each finished sum to the output FIFO. Rev 1.0
module conv_ctrl #(
  parameter  int R       = 8,
  parameter  int C       = 8,
  parameter  int MAXK    = 5,
  parameter  int MAC_LAT = 3,
  localparam int K_BITS  = $clog2(MAXK + 1),
  localparam int XW      = (R * C > 1) ? $clog2(R * C) : 1,
  localparam int WW      = (MAXK > 1) ? $clog2(MAXK * MAXK) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inputs_loaded,
  input  logic [K_BITS-1:0] K,
  output logic [XW-1:0]     X_read_addr,
  output logic [WW-1:0]     W_read_addr,
  output logic              mac_input_valid,
  output logic              mac_init_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              compute_finished
);

  localparam int RW   = $clog2(R + 1);
  localparam int CW   = $clog2(C + 1);
  localparam int DW   = $clog2(MAC_LAT + 1);
  localparam int KLIM = (R < C) ? ((R < MAXK) ? R : MAXK) : ((C < MAXK) ? C : MAXK);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, DONE} state_t;

  state_t            state_q, state_d;
  logic [K_BITS-1:0] kq_q, kq_d, i_q, i_d, j_q, j_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [XW-1:0]     x_addr_q, x_addr_d;
  logic [WW-1:0]     w_addr_q, w_addr_d;
  logic              issue_q, issue_d, init_q, init_d;
  logic              mac_valid_q, mac_init_q;
  logic              out_valid_q, out_valid_d, done_q, done_d;
  logic              k_ok, last_col, last_pix;
  logic [31:0]       x_sum, w_sum;

  assign k_ok     = (K != '0) && (32'(K) <= 32'(KLIM));
  assign last_col = (32'(c_q) == 32'(C) - 32'(kq_q));
  assign last_pix = last_col && (32'(r_q) == 32'(R) - 32'(kq_q));

  always_comb begin
    state_d = state_q;
    kq_d    = kq_q;
    r_d     = r_q;
    c_d     = c_q;
    i_d     = i_q;
    j_d     = j_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (inputs_loaded) begin
          kq_d    = K;
          r_d     = '0;
          c_d     = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = k_ok ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (j_q == kq_q - K_BITS'(1)) begin
          j_d = '0;
          if (i_q == kq_q - K_BITS'(1)) begin
            i_d     = '0;
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            i_d = i_q + K_BITS'(1);
          end
        end else begin
          j_d = j_q + K_BITS'(1);
        end
      end
      DRAIN: begin
        if (32'(drain_q) == 32'(MAC_LAT - 1)) begin
          state_d = OUT;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          if (last_pix) begin
            state_d = DONE;
          end else begin
            if (last_col) begin
              c_d = '0;
              r_d = r_q + RW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
            i_d     = '0;
            j_d     = '0;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are registered for the term the next cycle will issue; sums are 32-bit so no overflow.
  always_comb begin
    x_sum       = (32'(r_d) + 32'(i_d)) * 32'(C) + 32'(c_d) + 32'(j_d);
    w_sum       = 32'(i_d) * 32'(kq_d) + 32'(j_d);
    issue_d     = (state_d == ISSUE);
    init_d      = issue_d && (i_d == '0) && (j_d == '0);
    x_addr_d    = issue_d ? XW'(x_sum) : x_addr_q;
    w_addr_d    = issue_d ? WW'(w_sum) : w_addr_q;
    out_valid_d = (state_d == OUT);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kq_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      drain_q     <= '0;
      x_addr_q    <= '0;
      w_addr_q    <= '0;
      issue_q     <= 1'b0;
      init_q      <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_init_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kq_q        <= kq_d;
      r_q         <= r_d;
      c_q         <= c_d;
      i_q         <= i_d;
      j_q         <= j_d;
      drain_q     <= drain_d;
      x_addr_q    <= x_addr_d;
      w_addr_q    <= w_addr_d;
      issue_q     <= issue_d;
      init_q      <= init_d;
      // One-cycle delay matches the memory read latency.
      mac_valid_q <= issue_q;
      mac_init_q  <= init_q;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign X_read_addr      = x_addr_q;
  assign W_read_addr      = w_addr_q;
  assign mac_input_valid  = mac_valid_q;
  assign mac_init_acc     = mac_init_q;
  assign out_valid        = out_valid_q;
  assign compute_finished = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_ctrl.sv
`default_nettype none
// tb_conv_ctrl: directed bench for conv_ctrl at R=C=8, MAXK=5, MAC_LAT=3, with a memory and
// MAC model so each handed-off sum is compared against a direct convolution.
module tb_conv_ctrl;
  localparam int R = 8, C = 8, MAXK = 5, MAC_LAT = 3;

  logic       clk = 1'b0, reset = 1'b1, inputs_loaded = 1'b0, out_ready = 1'b1;
  logic [2:0] K = '0;
  logic [5:0] X_read_addr;
  logic [4:0] W_read_addr;
  logic       mac_input_valid, mac_init_acc, out_valid, compute_finished;

  always #5 clk = ~clk;

  conv_ctrl #(.R(R), .C(C), .MAXK(MAXK), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset), .inputs_loaded(inputs_loaded), .K(K),
    .X_read_addr(X_read_addr), .W_read_addr(W_read_addr),
    .mac_input_valid(mac_input_valid), .mac_init_acc(mac_init_acc),
    .out_valid(out_valid), .out_ready(out_ready), .compute_finished(compute_finished)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t0 = 0, cur_k = 3;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories with one-cycle read latency feeding a MAC whose result lands MAC_LAT cycles later.
  logic [7:0]  xmem [64];
  logic [7:0]  wmem [32];
  logic [7:0]  bval;
  logic [7:0]  x_data, w_data;
  logic [31:0] pipe0, pipe1, pipe2;
  always @(posedge clk) begin
    x_data <= xmem[X_read_addr];
    w_data <= wmem[W_read_addr];
    if (mac_input_valid) pipe0 <= (mac_init_acc ? 32'(bval) : pipe0) + 32'(x_data) * 32'(w_data);
    pipe1 <= pipe0;
    pipe2 <= pipe1;
  end

  function automatic logic [31:0] ref_pix(input int r, input int c, input int k);
    logic [31:0] s;
    s = 32'(bval);
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        s += 32'(xmem[(r + i) * C + c + j]) * 32'(wmem[i * k + j]);
    return s;
  endfunction

  logic clr = 1'b0;
  int hs_count = 0, cf_count = 0, mv_count = 0, init_count = 0, ov_count = 0, mac_err = 0;
  int cf_cyc = 0, first_mv_cyc = -1;
  int hs_cyc[$];
  int xlog[$];
  int wlog[$];
  logic [5:0] prev_x = '0;
  logic [4:0] prev_w = '0;

  always @(negedge clk) begin
    if (clr) begin
      hs_count = 0; cf_count = 0; mv_count = 0; init_count = 0; ov_count = 0; mac_err = 0;
      cf_cyc = 0; first_mv_cyc = -1;
      hs_cyc.delete(); xlog.delete(); wlog.delete();
    end else begin
      if (mac_input_valid) begin
        if (first_mv_cyc < 0) first_mv_cyc = cyc;
        mv_count++;
        xlog.push_back(int'(prev_x));
        wlog.push_back(int'(prev_w));
      end
      if (mac_init_acc) init_count++;
      if (out_valid) ov_count++;
      if (compute_finished) begin cf_count++; cf_cyc = cyc; end
      if (out_valid && out_ready) begin
        if (pipe2 !== ref_pix(hs_count / (C - cur_k + 1), hs_count % (C - cur_k + 1), cur_k))
          mac_err++;
        hs_cyc.push_back(cyc);
        hs_count++;
      end
    end
    prev_x = X_read_addr;
    prev_w = W_read_addr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
  endtask

  task automatic start(input int k);
    cur_k = k;
    @(posedge clk); #1;
    K = 3'(k);
    inputs_loaded = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    inputs_loaded = 1'b0;
  endtask

  task automatic wait_cf(input string tag, input int budget);
    int n;
    n = 0;
    while (cf_count == 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, " finished within budget"}, 64'(cf_count != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_x[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int bad, c1;
    logic [5:0] x_before;

    for (int a = 0; a < 64; a++) xmem[a] = 8'($urandom_range(0, 15));
    for (int a = 0; a < 32; a++) wmem[a] = 8'($urandom_range(0, 15));
    bval = 8'($urandom_range(0, 100));

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset outputs", 64'({X_read_addr, W_read_addr, mac_input_valid, mac_init_acc,
                              out_valid, compute_finished}), 64'd0);

    // K=3, free-running output
    clear_logs();
    start(3);
    wait_cf("k3", 2000);
    chk("k3 first mac_input_valid", 64'(first_mv_cyc), 64'(t0 + 2));
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("k3 x[%0d]", i), 64'(xlog[i]), 64'(exp_x[i]));
      chk($sformatf("k3 w[%0d]", i), 64'(wlog[i]), 64'(i));
    end
    chk("k3 pixel1 first x", 64'(xlog[9]), 64'd1);
    chk("k3 handshakes", 64'(hs_count), 64'd36);
    chk("k3 cf pulses", 64'(cf_count), 64'd1);
    chk("k3 mv count", 64'(mv_count), 64'd324);
    chk("k3 init count", 64'(init_count), 64'd36);
    chk("k3 ov cycles", 64'(ov_count), 64'd36);
    chk("k3 total cycles", 64'(hs_cyc[35] - (t0 + 1) + 1), 64'd468);
    chk("k3 cf after last hs", 64'(cf_cyc), 64'(hs_cyc[35] + 1));
    chk("k3 mac results", 64'(mac_err), 64'd0);

    // K=3, backpressure on pixel 0
    clear_logs();
    out_ready = 1'b0;
    start(3);
    bad = 0;
    while (!out_valid && bad < 100) begin @(negedge clk); bad++; end
    c1 = cyc;
    chk("stall out_valid rise", 64'(c1), 64'(t0 + 13));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("stall hold", 64'({out_valid, mac_input_valid, X_read_addr}), 64'({1'b1, 1'b0, 6'd18}));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("stall 6th cycle valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("stall resume issue", 64'({out_valid, X_read_addr, W_read_addr}), 64'({1'b0, 6'd1, 5'd0}));
    wait_cf("stall", 2000);
    chk("stall handshakes", 64'(hs_count), 64'd36);
    chk("stall ov cycles", 64'(ov_count), 64'd41);
    chk("stall mac results", 64'(mac_err), 64'd0);

    // K=1
    clear_logs();
    start(1);
    wait_cf("k1", 2000);
    chk("k1 handshakes", 64'(hs_count), 64'd64);
    bad = 0;
    for (int p = 0; p < 64; p++) if (xlog[p] != p || wlog[p] != 0) bad++;
    chk("k1 addresses", 64'(bad), 64'd0);
    chk("k1 init every term", 64'(init_count), 64'd64);
    chk("k1 mv count", 64'(mv_count), 64'd64);
    chk("k1 period", 64'(hs_cyc[1] - hs_cyc[0]), 64'(MAC_LAT + 2));
    chk("k1 span", 64'(hs_cyc[63] - hs_cyc[0]), 64'(63 * (MAC_LAT + 2)));
    chk("k1 mac results", 64'(mac_err), 64'd0);

    // K=5 against the reference convolution
    clear_logs();
    start(5);
    wait_cf("k5", 2000);
    chk("k5 handshakes", 64'(hs_count), 64'd16);
    chk("k5 mv count", 64'(mv_count), 64'd400);
    chk("k5 last pixel first x", 64'(xlog[15 * 25]), 64'd27);
    chk("k5 last x", 64'(xlog[399]), 64'd63);
    chk("k5 mac results", 64'(mac_err), 64'd0);

    // Invalid kernel sizes
    foreach (exp_x[n]) begin
      int kbad;
      if (n > 2) break;
      kbad = (n == 0) ? 0 : (n == 1) ? 6 : 7;
      clear_logs();
      x_before = X_read_addr;
      start(kbad);
      wait_cf($sformatf("kbad%0d", kbad), 50);
      chk($sformatf("kbad%0d cf cycle", kbad), 64'(cf_cyc), 64'(t0 + 1));
      chk($sformatf("kbad%0d activity", kbad), 64'(hs_count + mv_count + ov_count), 64'd0);
      chk($sformatf("kbad%0d x held", kbad), 64'(X_read_addr), 64'(x_before));
    end

    // Reset during ISSUE of pixel 10
    clear_logs();
    start(3);
    bad = 0;
    while (hs_count < 10 && bad < 2000) begin @(posedge clk); #2; bad++; end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("pre-reset pixel10 term1 x", 64'(X_read_addr), 64'd13);
    @(negedge clk);
    chk("post-reset outputs", 64'({X_read_addr, W_read_addr, mac_input_valid, mac_init_acc,
                                   out_valid, compute_finished}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post-reset no cf", 64'(cf_count), 64'd0);
    chk("post-reset idle", 64'({mac_input_valid, out_valid}), 64'd0);
    clear_logs();
    start(3);
    wait_cf("restart", 2000);
    chk("restart x0", 64'(xlog[0]), 64'd0);
    chk("restart x2", 64'(xlog[2]), 64'd2);
    chk("restart handshakes", 64'(hs_count), 64'd36);
    chk("restart mac results", 64'(mac_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
